// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM states, default widths and requester indices for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2} state_t;
  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 8;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/memory_unit.sv
// memory_unit: single-port word memory, write or registered read when select is high
// Ports: clk; select/op (1=write) /addr/data_in access command; data_out read word, valid the cycle after a read.
module memory_unit import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              select,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (select && op) r_mem[addr] <= data_in;
    if (select && !op) data_out <= r_mem[addr];
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-requester arbiter in front of a memory_unit, one access per 3 cycles
// Ports: clk, rst (sync, active high); reqN/weN/addrN/wdataN request from requester N;
// ackN one-cycle completion pulse, rdataN read data in the ack cycle of a read; busy high outside IDLE.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy
);
  state_t r_state, w_next;
  logic r_last, r_we, r_sel, r_op;
  logic [ADDR_W-1:0] r_maddr, w_addr;
  logic [DATA_W-1:0] r_mdata, w_wdata, w_dout;
  logic w_win, w_we, w_start, w_done;
  memory_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk(clk), .select(r_sel), .op(r_op), .addr(r_maddr), .data_in(r_mdata), .data_out(w_dout)
  );
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  // r_last doubles as the index of the transaction in flight: it only changes on entry to ISSUE
  always_comb begin
    w_win = (req1 && (!req0 || r_last == REQ0)) ? REQ1 : REQ0;
    w_we = w_win ? we1 : we0;
    w_addr = w_win ? addr1 : addr0;
    w_wdata = w_win ? wdata1 : wdata0;
    w_start = r_state == IDLE && (req0 || req1);
    w_next = r_state == ISSUE ? DONE : w_start ? ISSUE : IDLE;
    w_done = r_state == DONE && !rst;
    busy = r_state != IDLE;
    ack0 = w_done && r_last == REQ0;
    ack1 = w_done && r_last == REQ1;
    rdata0 = ack0 && !r_we ? w_dout : '0;
    rdata1 = ack1 && !r_we ? w_dout : '0;
  end
  // memory command registers are loaded only on entry to ISSUE, so they are zero in every other state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= REQ1;
      r_we <= 1'b0;
      r_sel <= 1'b0;
      r_op <= 1'b0;
      r_maddr <= '0;
      r_mdata <= '0;
    end else begin
      r_sel <= w_start;
      r_op <= w_start && w_we;
      r_maddr <= w_start ? w_addr : '0;
      r_mdata <= w_start && w_we ? w_wdata : '0;
      if (w_start) begin
        r_last <= w_win;
        r_we <= w_we;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a transaction-level model checked every cycle
module tb_mem_arbiter;
  logic clk = 0, rst = 1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [2:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0;
  logic ack0, ack1, busy;
  logic [7:0] rdata0, rdata1;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  mem_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // Transaction model: an accepted request occupies the next two cycles and is acknowledged in the second
  int cyc = 0, m_ack = -10;
  logic m_last = 1, m_who = 0, m_we = 0;
  logic [7:0] m_data = 0;
  logic [7:0] m_mem [8];
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_ack = -10;
      m_last = 1;
    end else if (cyc - 1 > m_ack && (req0 || req1)) begin
      m_who = (req0 && req1) ? !m_last : req1;
      m_last = m_who;
      m_we = m_who ? we1 : we0;
      if (m_we) m_mem[m_who ? addr1 : addr0] = m_who ? wdata1 : wdata0;
      m_data = m_we ? 8'h00 : m_mem[m_who ? addr1 : addr0];
      m_ack = cyc + 1;
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      logic e0, e1;
      e0 = cyc == m_ack && m_who == 0 && !rst;
      e1 = cyc == m_ack && m_who == 1 && !rst;
      chk("busy", busy, cyc == m_ack || cyc == m_ack - 1);
      chk("select", dut.r_sel, cyc == m_ack - 1);
      chk("ack0", ack0, e0);
      chk("ack1", ack1, e1);
      chk("rdata0", rdata0, e0 && !m_we ? m_data : 8'h00);
      chk("rdata1", rdata1, e1 && !m_we ? m_data : 8'h00);
      chk("ack_excl", ack0 && ack1, 0);
    end
  end
  task automatic access(input int p, input logic we, input logic [2:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd);
    @(posedge clk); #1;
    if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
    else begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
    lat = -1;
    rd = 0;
    for (int n = 0; n < 12 && lat < 0; n++) begin
      @(negedge clk);
      if (p == 0 ? ack0 : ack1) begin
        lat = n;
        rd = p == 0 ? rdata0 : rdata1;
      end
    end
    @(posedge clk); #1;
    if (p == 0) req0 = 0; else req1 = 0;
  endtask
  int l0, l1, n;
  logic [7:0] r0, r1;
  int who [6];
  int at [6];
  logic [7:0] dat [6];
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_ack", {ack0, ack1}, 0);
    fork
      access(0, 1, 3'd0, 8'hCC, l0, r0);
      access(1, 1, 3'd7, 8'h33, l1, r1);
    join
    chk("sim_lat0", l0, 2);
    chk("sim_lat1", l1, 5);
    access(1, 0, 3'd0, 8'h00, l1, r1);
    chk("rd_a0_lat", l1, 2);
    chk("rd_a0", r1, 8'hCC);
    access(0, 0, 3'd7, 8'h00, l0, r0);
    chk("rd_a7", r0, 8'h33);
    access(0, 1, 3'd1, 8'h49, l0, r0);
    chk("wr49_lat", l0, 2);
    access(0, 0, 3'd1, 8'h00, l0, r0);
    chk("rd49_lat", l0, 2);
    chk("rd49", r0, 8'h49);
    access(0, 1, 3'd7, 8'hA5, l0, r0);
    access(1, 1, 3'd0, 8'h5A, l1, r1);
    access(0, 0, 3'd7, 8'h00, l0, r0);
    chk("wrap_a7", r0, 8'hA5);
    access(1, 0, 3'd0, 8'h00, l1, r1);
    chk("wrap_a0", r1, 8'h5A);
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 3'd7;
    req1 = 1; we1 = 0; addr1 = 3'd0;
    n = 0;
    for (int t = 0; t < 40 && n < 6; t++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        who[n] = ack1 ? 1 : 0;
        at[n] = t;
        dat[n] = ack1 ? rdata1 : rdata0;
        n++;
      end
    end
    @(posedge clk); #1;
    req0 = 0; req1 = 0;
    chk("fair_count", n, 6);
    chk("fair_first", at[0], 2);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fair_who%0d", i), who[i], i % 2);
      chk($sformatf("fair_dat%0d", i), dat[i], i % 2 ? 8'h5A : 8'hA5);
      if (i > 0) chk($sformatf("fair_gap%0d", i), at[i] - at[i-1], 3);
    end
    @(posedge clk); #1;
    req0 = 1; we0 = 0; addr0 = 3'd1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1;
    req0 = 0;
    @(negedge clk);
    chk("abort_ack", ack0, 0);
    chk("abort_busy", busy, 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_out", {ack0, ack1, rdata0, rdata1, busy, dut.r_sel}, 0);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || ack0 || ack1 || dut.r_sel) n++;
    end
    chk("idle_quiet", n, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
